// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: arbiter states,
// data width and the round-robin slot helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Slot visited at step 'off' of a circular search that starts at 'base'.
    function automatic int rr_slot(int base, int off, int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin select: first set bit of req starting at ptr,
// wrapping modulo NREQ. Kept generic so an RX event distributor can reuse it.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    any,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] slot;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        slot = '0;
        for (int off = 0; off < NREQ; off++) begin
            slot = IDX_W'(rr_slot(int'(ptr), off, NREQ));
            if (!any && req[slot]) begin
                any = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte sources; a grant
// is held for a whole req_last-terminated frame, with a stall timeout.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          cfg_txen,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [UART_DATA_W*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]               req_last,
    output logic [NREQ-1:0]               req_ready,
    output logic                          tx_valid,
    output logic [UART_DATA_W-1:0]        tx_data,
    input  logic                          tx_ready,
    output logic [$clog2(NREQ)-1:0]       owner,
    output logic                          busy,
    output logic                          drop_pulse
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t             state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       next_ptr;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [TO_W-1:0]        to_cnt;
    logic                   own_valid;
    logic                   own_last;
    logic [UART_DATA_W-1:0] own_data;
    logic                   accept;
    logic                   timeout_hit;
    logic [UART_DATA_W-1:0] req_bytes [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*UART_DATA_W +: UART_DATA_W];
    end

    uart_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign own_valid   = req_valid[owner];
    assign own_last    = req_last[owner];
    assign own_data    = req_bytes[owner];
    assign busy        = (state == LOCK);
    // uart_tx ignores tx_valid while disabled, so cfg_txen gates the handshake.
    assign accept      = busy && own_valid && tx_ready && cfg_txen;
    assign timeout_hit = (TIMEOUT > 0) && busy && !own_valid
                         && (to_cnt == TO_W'(TIMEOUT - 1));
    assign next_ptr    = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (busy) begin
            tx_valid = own_valid;
            tx_data  = own_data;
            req_ready[owner] = tx_ready && cfg_txen;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            to_cnt     <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            if (state == IDLE) begin
                if (pick_any) begin
                    owner  <= pick_idx;
                    state  <= LOCK;
                    to_cnt <= '0;
                end
            end else begin
                if (accept && own_last) begin
                    state  <= IDLE;
                    rr_ptr <= next_ptr;
                    to_cnt <= '0;
                end else if (timeout_hit) begin
                    state      <= IDLE;
                    rr_ptr     <= next_ptr;
                    to_cnt     <= '0;
                    drop_pulse <= 1'b1;
                end else if (own_valid) begin
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (NREQ=4, TIMEOUT=8): frames, fairness,
// no-interleave, timeout, cfg_txen gating and asynchronous reset mid-frame.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cfg_txen;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  owner;
    logic        busy;
    logic        drop_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_tx_arb #(.NREQ(4), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .cfg_txen   (cfg_txen),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .owner      (owner),
        .busy       (busy),
        .drop_pulse (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]        = v;
        req_data[8*i +: 8]  = d;
        req_last[i]         = l;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_b     = 1'b0;
        cfg_txen  = 1'b1;
        tx_ready  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        #2;
        check_output("rst_tx_valid", 32'(tx_valid), 32'h0);
        check_output("rst_tx_data", 32'(tx_data), 32'h0);
        check_output("rst_req_ready", 32'(req_ready), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_drop", 32'(drop_pulse), 32'h0);
        check_output("rst_owner", 32'(owner), 32'h0);

        // Single frame from requester 1 with uart_tx backpressure
        tick();
        rst_b = 1'b1;
        apply_stimulus(1, 1'b1, 8'h41, 1'b0);
        tick();
        check_output("f1_busy", 32'(busy), 32'h1);
        check_output("f1_owner", 32'(owner), 32'h1);
        check_output("f1_tx_valid", 32'(tx_valid), 32'h1);
        check_output("f1_data41", 32'(tx_data), 32'h41);
        check_output("f1_ready41", 32'(req_ready), 32'h2);
        tick();
        tx_ready = 1'b0;
        apply_stimulus(1, 1'b1, 8'h42, 1'b0);
        #1;
        check_output("f1_data42", 32'(tx_data), 32'h42);
        check_output("f1_ready_bp", 32'(req_ready), 32'h0);
        repeat (3) tick();
        tx_ready = 1'b1;
        #1;
        check_output("f1_ready42", 32'(req_ready), 32'h2);
        tick();
        tx_ready = 1'b0;
        apply_stimulus(1, 1'b1, 8'h43, 1'b1);
        #1;
        check_output("f1_data43", 32'(tx_data), 32'h43);
        check_output("f1_busy_mid", 32'(busy), 32'h1);
        tick();
        tx_ready = 1'b1;
        #1;
        check_output("f1_ready43", 32'(req_ready), 32'h2);
        tick();
        check_output("f1_busy_fall", 32'(busy), 32'h0);
        check_output("f1_idle_tx_valid", 32'(tx_valid), 32'h0);
        check_output("f1_owner_hold", 32'(owner), 32'h1);
        apply_stimulus(0, 1'b1, 8'h0C, 1'b1);
        apply_stimulus(1, 1'b1, 8'h1C, 1'b1);
        apply_stimulus(3, 1'b1, 8'h3C, 1'b1);
        tick();
        check_output("f1_rrptr2_owner", 32'(owner), 32'h3);
        check_output("f1_rrptr2_data", 32'(tx_data), 32'h3C);

        // Fairness: all four requesters continuously valid
        tick();
        for (int i = 0; i < 4; i++) apply_stimulus(i, 1'b1, 8'(8'hA0 + i), 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_output($sformatf("fair_owner%0d", k), 32'(owner), 32'(k % 4));
            check_output($sformatf("fair_data%0d", k), 32'(tx_data), 32'(8'hA0 + k % 4));
            tick();
        end

        // No interleave: req0 frame while req2 waits
        for (int i = 0; i < 4; i++) apply_stimulus(i, 1'b0, 8'h00, 1'b0);
        apply_stimulus(0, 1'b1, 8'h10, 1'b0);
        tick();
        check_output("ni_owner0", 32'(owner), 32'h0);
        apply_stimulus(2, 1'b1, 8'h20, 1'b1);
        #1;
        check_output("ni_data10", 32'(tx_data), 32'h10);
        check_output("ni_ready10", 32'(req_ready), 32'h1);
        tick();
        apply_stimulus(0, 1'b1, 8'h11, 1'b0);
        #1;
        check_output("ni_data11", 32'(tx_data), 32'h11);
        check_output("ni_ready11", 32'(req_ready), 32'h1);
        tick();
        apply_stimulus(0, 1'b1, 8'h12, 1'b1);
        #1;
        check_output("ni_data12", 32'(tx_data), 32'h12);
        check_output("ni_owner_held", 32'(owner), 32'h0);
        tick();
        check_output("ni_gap_busy", 32'(busy), 32'h0);
        check_output("ni_gap_ready", 32'(req_ready), 32'h0);
        apply_stimulus(0, 1'b0, 8'h00, 1'b0);
        tick();
        check_output("ni_owner2", 32'(owner), 32'h2);
        check_output("ni_data20", 32'(tx_data), 32'h20);
        check_output("ni_ready20", 32'(req_ready), 32'h4);

        // Timeout: req3 stalls mid-frame, req1 waiting
        tick();
        apply_stimulus(2, 1'b0, 8'h00, 1'b0);
        apply_stimulus(3, 1'b1, 8'h33, 1'b0);
        tick();
        check_output("to_owner3", 32'(owner), 32'h3);
        check_output("to_data33", 32'(tx_data), 32'h33);
        tick();
        apply_stimulus(3, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1, 1'b1, 8'h55, 1'b1);
        for (int k = 0; k < 7; k++) begin
            tick();
            check_output($sformatf("to_wait_drop%0d", k), 32'(drop_pulse), 32'h0);
            check_output($sformatf("to_wait_busy%0d", k), 32'(busy), 32'h1);
        end
        tick();
        check_output("to_drop", 32'(drop_pulse), 32'h1);
        check_output("to_released", 32'(busy), 32'h0);
        tick();
        check_output("to_drop_once", 32'(drop_pulse), 32'h0);
        check_output("to_next_owner", 32'(owner), 32'h1);
        check_output("to_next_busy", 32'(busy), 32'h1);

        // cfg_txen gating: grant held, nothing accepted, no timeout
        tick();
        apply_stimulus(1, 1'b0, 8'h00, 1'b0);
        cfg_txen = 1'b0;
        apply_stimulus(0, 1'b1, 8'h77, 1'b1);
        tick();
        check_output("en_owner0", 32'(owner), 32'h0);
        check_output("en_tx_valid", 32'(tx_valid), 32'h1);
        check_output("en_ready_off", 32'(req_ready), 32'h0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_output($sformatf("en_hold_busy%0d", k), 32'(busy), 32'h1);
            check_output($sformatf("en_hold_drop%0d", k), 32'(drop_pulse), 32'h0);
            check_output($sformatf("en_hold_ready%0d", k), 32'(req_ready), 32'h0);
        end
        cfg_txen = 1'b1;
        #1;
        check_output("en_ready_on", 32'(req_ready), 32'h1);
        tick();
        check_output("en_accepted", 32'(busy), 32'h0);

        // Asynchronous reset mid-frame
        apply_stimulus(0, 1'b0, 8'h00, 1'b0);
        apply_stimulus(2, 1'b1, 8'h99, 1'b0);
        tick();
        check_output("ar_owner2", 32'(owner), 32'h2);
        check_output("ar_busy_pre", 32'(busy), 32'h1);
        #2;
        rst_b = 1'b0;
        #1;
        check_output("ar_tx_valid", 32'(tx_valid), 32'h0);
        check_output("ar_busy", 32'(busy), 32'h0);
        check_output("ar_req_ready", 32'(req_ready), 32'h0);
        check_output("ar_owner", 32'(owner), 32'h0);
        tick();
        rst_b = 1'b1;
        apply_stimulus(0, 1'b1, 8'hAB, 1'b1);
        tick();
        check_output("ar_fresh_owner", 32'(owner), 32'h0);
        check_output("ar_fresh_data", 32'(tx_data), 32'hAB);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares one uart_tx byte transmitter between NREQ independent byte sources.
- Grants are round-robin and held for a whole frame: a multi-byte message, terminated by req_last, goes out with no interleaving.
- A timeout releases a requester that stalls mid-frame.
- Sits between the client logic (register bank, debug/log sources) and uart_tx's tx_valid/tx_data/tx_ready interface.

Parameters:
- NREQ, 4, number of requesters (2..16).
- TIMEOUT, 1024, clock cycles an owner may hold the grant with req_valid low before forced release; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- cfg_txen  in  1  transmit enable, the same signal driven to uart_tx
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i]
- req_last  in  NREQ  marks the final byte of a frame; qualified by req_valid
- req_ready  out  NREQ  per-requester accept
- tx_valid  out  1  to uart_tx
- tx_data  out  8  to uart_tx
- tx_ready  in  1  from uart_tx; high while it is idle
- owner  out  $clog2(NREQ)  index of the current grant holder
- busy  out  1  high while in LOCK
- drop_pulse  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset: clk and rst_b are the only clock and reset. Reset is asynchronous, active-low, and applies to every flop.
- Reset values: state=IDLE, rr_ptr=0, owner=0, to_cnt=0. tx_valid=0, tx_data=0, req_ready=0, busy=0, drop_pulse=0.
- Accept condition: a byte is accepted only when tx_valid & tx_ready & cfg_txen are all high, because uart_tx ignores tx_valid while cfg_txen=0. req_ready[i] = (state==LOCK) & (owner==i) & tx_ready & cfg_txen.
- IDLE state:
  - tx_valid=0 and all req_ready=0.
  - If any req_valid bit is set, pick the first set bit searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - Register the winner into owner, go to LOCK, clear to_cnt.
  - Grant latency: 1 cycle from req_valid to tx_valid.
- LOCK state:
  - tx_valid = req_valid[owner] and tx_data = req_data[owner], both combinational pass-through.
  - Non-owner requests are ignored.
- LOCK -> IDLE on accept with req_last[owner]=1. Then rr_ptr = owner+1, wrapping NREQ-1 -> 0.
- Timeout (TIMEOUT>0):
  - to_cnt increments each LOCK cycle in which req_valid[owner]=0, and clears whenever req_valid[owner]=1.
  - When to_cnt==TIMEOUT-1 and req_valid[owner] is still 0: go to IDLE, pulse drop_pulse for 1 cycle, set rr_ptr = owner+1.
- Simultaneous events:
  - A last-byte accept and new requests in the same cycle: the new requests are arbitrated in IDLE on the next cycle (1 bubble cycle, negligible against the UART bit time).
  - Timeout and an accept cannot coincide, because an accept requires req_valid=1.
- cfg_txen=0 during LOCK: the grant is held and nothing is accepted. The timeout counter is unaffected while the owner keeps req_valid high.
- Multi-cycle backpressure: tx_ready stays low for a whole UART frame. The owner must hold req_valid and req_data stable until accepted.
- Reset mid-frame: the block returns to IDLE immediately. The byte already latched by uart_tx completes; the rest of the frame is lost, and clients must restart it.
- owner holds its last value in IDLE; busy = (state==LOCK).

Decomposition:
- Shared package uart_pkg holds:
  - the arb_state_t enum {IDLE, LOCK};
  - UART_DATA_W=8.
- One sub-module, uart_rr_pick: purely combinational round-robin select. Inputs are req[NREQ] and ptr; outputs are any and idx. It is reusable for a future RX event distributor.
- Counter and FSM stay in uart_tx_arb.

Test Plan:
- Single frame: NREQ=4, req1 sends 0x41,0x42,0x43 (last on 0x43) with tx_ready toggling per a uart_tx model -> tx_data sequence 41,42,43; owner=1; busy falls the cycle after the 0x43 accept; rr_ptr=2.
- Fairness: all 4 requesters send single-byte frames continuously from reset -> grant order 0,1,2,3,0,…; no requester gets two consecutive grants while another is valid.
- No interleave: req0 sends a 3-byte frame while req2 is valid throughout -> all req0 bytes go out before any req2 byte; req_ready[2] stays 0 until req0's last byte is accepted.
- Timeout: TIMEOUT=8; req3 sends one non-last byte then drops valid -> drop_pulse exactly 8 LOCK cycles after valid fell; the next valid requester is granted 1 cycle later.
- cfg_txen gating: cfg_txen=0 with req0 valid and tx_ready=1 -> tx_valid=1, req_ready[0]=0, no accept, no timeout; raising cfg_txen gives an accept in the same cycle.
- Async reset mid-frame: assert rst_b low between clock edges during LOCK -> tx_valid, busy and req_ready all drop to 0 before the next edge; after release the block arbitrates afresh from rr_ptr=0.
